hmac_arbiter: RTL
=================

Name: hmac_arbiter

Overview:
- Shares one HMAC core between two requesters: the PBKDF2 key-derivation engine and a message-authentication client.
- Round-robin arbitration; latches the winner's key/message and drives the core's start pulse.
- Waits for the core's done pulse, then returns the 256-bit MAC to the granted requester only.
- A watchdog detects a hung core and parks the block in FAULT until software clears it.

Parameters:
KEY_W, 1088, HMAC key width in bits (max 136-byte password)
MSG_W, 1088, padded HMAC message block width in bits
MAC_W, 256, MAC output width in bits
TIMEOUT_CYC, 4096, max cycles in BUSY before fault (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester request level; bit0 = PBKDF2, bit1 = MAC client
req_key  input  2*KEY_W  per-requester key; requester i at [i*KEY_W +: KEY_W]
req_msg  input  2*MSG_W  per-requester message; requester i at [i*MSG_W +: MSG_W]
req_ack  output  2  one-cycle pulse: request i accepted, inputs latched
resp_valid  output  2  one-cycle pulse: result for requester i available
resp_mac  output  MAC_W  MAC for the responding requester
resp_err  output  1  qualifies resp_valid: 1 = timeout, resp_mac = 0
hmac_start  output  1  one-cycle start pulse to the HMAC core
hmac_key  output  KEY_W  registered key to the core
hmac_msg  output  MSG_W  registered message to the core
hmac_mac  input  MAC_W  core MAC output
hmac_ready  input  1  core done pulse; hmac_mac valid in the same cycle
fault  output  1  level, high while in FAULT
fault_clr  input  1  one-cycle clear, leaves FAULT

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; all outputs 0; hmac_key/hmac_msg/resp_mac = 0.
  - last_gnt = 1, so requester 0 wins the first tie.
  - Watchdog counter = 0.
- All outputs are registered.
- States: IDLE -> ISSUE -> BUSY -> DONE -> IDLE; BUSY -> FAULT -> IDLE.
- IDLE:
  - If any req_valid is set, pick the winner g: the only valid requester, or on both valid, the one != last_gnt.
  - Next cycle (ISSUE): req_ack[g]=1, hmac_start=1, hmac_key/hmac_msg hold the latched req_key/req_msg of g; last_gnt = g.
- ISSUE lasts exactly one cycle, then BUSY with hmac_start=0 and the watchdog cleared.
  - hmac_ready during ISSUE is ignored.
- Requester contract:
  - key/msg need only be stable in the cycle the arbiter samples them in IDLE.
  - req_valid must drop in the cycle after req_ack unless a new request is intended.
  - A still-high req_valid is treated as a new request at the next IDLE.
- BUSY:
  - Watchdog increments each cycle.
  - On hmac_ready=1: latch hmac_mac into resp_mac; next cycle is DONE.
  - If hmac_ready and watchdog == TIMEOUT_CYC-1 occur in the same cycle, ready wins (normal completion).
- DONE (one cycle): resp_valid[g]=1, resp_err=0, resp_mac valid.
  - Next cycle returns to IDLE; resp_valid clears.
  - resp_mac holds its value until the next DONE or FAULT entry.
- Timeout: watchdog reaches TIMEOUT_CYC-1 in BUSY with no hmac_ready.
  - Next cycle enters FAULT: resp_valid[g]=1 and resp_err=1 for one cycle, resp_mac=0, fault=1.
- FAULT:
  - No grants; hmac_ready ignored; fault stays high.
  - fault_clr=1 -> IDLE next cycle, fault=0.
  - fault_clr outside FAULT is ignored.
- Minimum turnaround: request sampled at t -> ack/start at t+1 -> earliest next grant sampled at the IDLE cycle after DONE.
- hmac_ready outside BUSY (IDLE, DONE, FAULT) is ignored; no response is generated.
- Asynchronous reset mid-job:
  - Abandons the job with no response.
  - Arbiter returns to IDLE at once; hmac_start=0.

Test Plan:
1. Single PBKDF2 request: req_valid=2'b01, key=K0, msg=M0; core ready 5 cycles after start with mac=0xA5..A5 -> req_ack=2'b01 one cycle, hmac_start one cycle with hmac_key=K0, resp_valid=2'b01 one cycle after ready, resp_mac=0xA5..A5, resp_err=0.
2. Both valid from reset -> requester 0 acked first; after its DONE, requester 1 acked; a third tie grants 0 again (strict alternation).
3. Requester 1 only, repeated 3 times back-to-back -> each served in turn, no starvation logic blocks a lone requester, hmac_start pulses exactly 3 times.
4. Spurious hmac_ready in IDLE and in ISSUE -> no resp_valid, state unaffected; real ready later completes normally.
5. TIMEOUT_CYC=8, core never asserts ready -> 8 cycles in BUSY, then resp_valid[g]=1 with resp_err=1, resp_mac=0, fault=1; new req_valid not acked; fault_clr -> fault=0 and the pending request is acked next IDLE.
6. Assert rst_n=0 during BUSY -> all outputs 0 immediately; after release, a new request is granted to requester 0 on a tie.

Source files
------------

// File: rtl/hmac_arb_if.sv
// Bundle of requester-side and core-side signals around the shared HMAC arbiter.
// slave is the arbiter's view; master is the view of the requesters and HMAC core.
interface hmac_arb_if #(
    parameter int KEY_W = 1088,
    parameter int MSG_W = 1088,
    parameter int MAC_W = 256
);
    logic [1:0]         req_valid;
    logic [2*KEY_W-1:0] req_key;
    logic [2*MSG_W-1:0] req_msg;
    logic [1:0]         req_ack;
    logic [1:0]         resp_valid;
    logic [MAC_W-1:0]   resp_mac;
    logic               resp_err;
    logic               hmac_start;
    logic [KEY_W-1:0]   hmac_key;
    logic [MSG_W-1:0]   hmac_msg;
    logic [MAC_W-1:0]   hmac_mac;
    logic               hmac_ready;
    logic               fault;
    logic               fault_clr;

    modport slave (
        input  req_valid, req_key, req_msg, hmac_mac, hmac_ready, fault_clr,
        output req_ack, resp_valid, resp_mac, resp_err, hmac_start, hmac_key, hmac_msg, fault
    );

    modport master (
        output req_valid, req_key, req_msg, hmac_mac, hmac_ready, fault_clr,
        input  req_ack, resp_valid, resp_mac, resp_err, hmac_start, hmac_key, hmac_msg, fault
    );
endinterface

// File: rtl/hmac_arbiter.sv
// Round-robin arbiter sharing one HMAC core between the PBKDF2 engine (0) and a MAC client (1),
// with a BUSY watchdog that parks the block in FAULT until software clears it.
module hmac_arbiter #(
    parameter int KEY_W       = 1088,
    parameter int MSG_W       = 1088,
    parameter int MAC_W       = 256,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic      clk,
    input  logic      rst_n,
    hmac_arb_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             r_state;
    logic               r_last_gnt;
    logic [WD_W-1:0]    r_wd;
    logic [1:0]         r_ack;
    logic [1:0]         r_resp_valid;
    logic [MAC_W-1:0]   r_resp_mac;
    logic               r_resp_err;
    logic               r_start;
    logic [KEY_W-1:0]   r_key;
    logic [MSG_W-1:0]   r_msg;
    logic               r_fault;

    logic               w_gnt;
    logic               w_wd_expired;

    function automatic logic [1:0] onehot(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    // On a tie the requester that was not served last wins; a lone requester always wins.
    assign w_gnt        = (bus.req_valid == 2'b11) ? ~r_last_gnt : bus.req_valid[1];
    assign w_wd_expired = (r_wd == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_gnt   <= 1'b1;
            r_wd         <= '0;
            r_ack        <= '0;
            r_resp_valid <= '0;
            r_resp_mac   <= '0;
            r_resp_err   <= 1'b0;
            r_start      <= 1'b0;
            r_key        <= '0;
            r_msg        <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_ack        <= '0;
            r_start      <= 1'b0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        r_ack      <= onehot(w_gnt);
                        r_start    <= 1'b1;
                        r_key      <= w_gnt ? bus.req_key[KEY_W +: KEY_W] : bus.req_key[0 +: KEY_W];
                        r_msg      <= w_gnt ? bus.req_msg[MSG_W +: MSG_W] : bus.req_msg[0 +: MSG_W];
                        r_last_gnt <= w_gnt;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    // A done pulse in the final watchdog cycle still counts as normal completion.
                    if (bus.hmac_ready) begin
                        r_resp_mac   <= bus.hmac_mac;
                        r_resp_valid <= onehot(r_last_gnt);
                        r_state      <= S_DONE;
                    end else if (w_wd_expired) begin
                        r_resp_mac   <= '0;
                        r_resp_valid <= onehot(r_last_gnt);
                        r_resp_err   <= 1'b1;
                        r_fault      <= 1'b1;
                        r_state      <= S_FAULT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    if (bus.fault_clr) begin
                        r_fault <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack    = r_ack;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_mac   = r_resp_mac;
    assign bus.resp_err   = r_resp_err;
    assign bus.hmac_start = r_start;
    assign bus.hmac_key   = r_key;
    assign bus.hmac_msg   = r_msg;
    assign bus.fault      = r_fault;
endmodule
